// File: rtl/load_store_unit.sv
// Load/store unit for a MIPS-style pipeline.
//
// It accepts one memory op from decode, computes the effective address (EA),
// drives one memory request and returns sign- or zero-extended load data.
// Misaligned half and word accesses raise a one-cycle exception and are not
// sent to memory.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   valid_i / ready_o          op handshake from decode (ready only in IDLE)
//   opcode_i, base_i,          MIPS opcode, rs value, extended offset,
//   imm_ext_i, store_data_i,   rt value for stores,
//   rt_i                       load destination register
//   mem_req_o, mem_we_o,       memory request: write flag, word-aligned address,
//   mem_addr_o, mem_be_o,      byte enables (bit n covers bits 8n+7:8n),
//   mem_wdata_o                replicated write data
//   mem_rdata_i, mem_ack_i     read data and completion (only used in ACCESS)
//   wb_valid_o, wb_rd_o,       one-cycle load writeback
//   wb_data_o
//   exc_misalign_o,            one-cycle exception pulses; exc_badaddr_o holds
//   exc_timeout_o,             the EA of the most recent exception
//   exc_badaddr_o
//
// Configuration:
//   LSU_TIMEOUT_EN  when defined, an access that sees no mem_ack_i for
//                   TIMEOUT_CYCLES ACCESS cycles is aborted and exc_timeout_o
//                   pulses. When undefined, ACCESS waits indefinitely and
//                   exc_timeout_o is tied low.

module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [5:0]  opcode_i,
  input  logic [31:0] base_i,
  input  logic [31:0] imm_ext_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rt_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        exc_misalign_o,
  output logic        exc_timeout_o,
  output logic [31:0] exc_badaddr_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;
  localparam logic [1:0] StErr    = 2'd3;

  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpSb  = 6'b101000;
  localparam logic [5:0] OpSh  = 6'b101001;
  localparam logic [5:0] OpSw  = 6'b101011;

  // Only opcode[3:0] is kept: [3] = store, [2] = unsigned load,
  // [1:0] = size (00 byte, 01 half, 11 word).
  logic [1:0]  state_q, state_d;
  logic [31:0] ea_q, ea_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  rt_q, rt_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] badaddr_q, badaddr_d;

  logic        op_legal;
  logic [31:0] ea_in;
  logic        misalign_in;
  logic [31:0] lane;
  logic [31:0] load_ext;
  logic [3:0]  be;
  logic [31:0] wdata;

  assign ea_in = base_i + imm_ext_i;

  always_comb begin
    op_legal = 1'b0;
    case (opcode_i)
      OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw: op_legal = 1'b1;
      default:                                          op_legal = 1'b0;
    endcase
  end

  // Byte ops have size bits 00 and can never be misaligned.
  assign misalign_in = ((opcode_i[1:0] == 2'b01) && ea_in[0]) ||
                       ((opcode_i[1:0] == 2'b11) && (ea_in[1:0] != 2'b00));

  // Shift the addressed lane down to bit 0; aligned halves and words make
  // this shift correct for every access size.
  assign lane = mem_rdata_i >> {ea_q[1:0], 3'b000};

  always_comb begin
    load_ext = lane;
    case (op_q[1:0])
      2'b00:   load_ext = op_q[2] ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_ext = op_q[2] ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    be    = 4'b1111;
    wdata = sdata_q;
    case (op_q[1:0])
      2'b00: begin
        be    = 4'b0001 << ea_q[1:0];
        wdata = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        be    = ea_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = sdata_q;
      end
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_pulse_q, tmo_pulse_d;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    ea_d      = ea_q;
    op_d      = op_q;
    rt_d      = rt_q;
    sdata_d   = sdata_q;
    wb_data_d = wb_data_q;
    badaddr_d = badaddr_q;
`ifdef LSU_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_pulse_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (valid_i && op_legal) begin
          ea_d    = ea_in;
          op_d    = opcode_i[3:0];
          rt_d    = rt_i;
          sdata_d = store_data_i;
          if (misalign_in) begin
            state_d   = StErr;
            badaddr_d = ea_in;
          end else begin
            state_d = StAccess;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end
        end
      end
      StAccess: begin
        if (mem_ack_i) begin
          if (op_q[3]) begin
            state_d = StIdle;
          end else begin
            wb_data_d = load_ext;
            state_d   = StDone;
          end
        end else begin
`ifdef LSU_TIMEOUT_EN
          if (tmo_cnt_q == TIMEOUT_CYCLES - 1) begin
            state_d     = StIdle;
            tmo_pulse_d = 1'b1;
            badaddr_d   = ea_q;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
          end
`endif
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ea_q      <= '0;
      op_q      <= '0;
      rt_q      <= '0;
      sdata_q   <= '0;
      wb_data_q <= '0;
      badaddr_q <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      tmo_pulse_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ea_q      <= ea_d;
      op_q      <= op_d;
      rt_q      <= rt_d;
      sdata_q   <= sdata_d;
      wb_data_q <= wb_data_d;
      badaddr_q <= badaddr_d;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_pulse_q <= tmo_pulse_d;
`endif
    end
  end

  // Outputs are gated by reset directly so a request is dropped the moment
  // reset rises, independent of the register clear.
  always_comb begin
    ready_o        = 1'b0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_be_o       = '0;
    mem_wdata_o    = '0;
    wb_valid_o     = 1'b0;
    wb_rd_o        = '0;
    wb_data_o      = '0;
    exc_misalign_o = 1'b0;
    exc_timeout_o  = 1'b0;
    exc_badaddr_o  = '0;
    if (!reset) begin
      ready_o = (state_q == StIdle);
      if (state_q == StAccess) begin
        mem_req_o   = 1'b1;
        mem_we_o    = op_q[3];
        mem_addr_o  = {ea_q[31:2], 2'b00};
        mem_be_o    = be;
        mem_wdata_o = wdata;
      end
      wb_valid_o     = (state_q == StDone);
      wb_rd_o        = rt_q;
      wb_data_o      = wb_data_q;
      exc_misalign_o = (state_q == StErr);
      exc_badaddr_o  = badaddr_q;
`ifdef LSU_TIMEOUT_EN
      exc_timeout_o = tmo_pulse_q;
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int unsigned Tmo = 4;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;

  logic        clk;
  logic        reset;
  logic        valid_i;
  logic        ready_o;
  logic [5:0]  opcode_i;
  logic [31:0] base_i;
  logic [31:0] imm_ext_i;
  logic [31:0] store_data_i;
  logic [4:0]  rt_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        exc_misalign_o;
  logic        exc_timeout_o;
  logic [31:0] exc_badaddr_o;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_badaddr;

  load_store_unit #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .opcode_i      (opcode_i),
    .base_i        (base_i),
    .imm_ext_i     (imm_ext_i),
    .store_data_i  (store_data_i),
    .rt_i          (rt_i),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_be_o      (mem_be_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i),
    .mem_ack_i     (mem_ack_i),
    .wb_valid_o    (wb_valid_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o),
    .exc_misalign_o(exc_misalign_o),
    .exc_timeout_o (exc_timeout_o),
    .exc_badaddr_o (exc_badaddr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [5:0] op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      default:     return 4;
    endcase
  endfunction

  function automatic bit m_store(input logic [5:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic bit m_legal(input logic [5:0] op);
    return op inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
  endfunction

  function automatic bit m_misaligned(input logic [5:0] op, input logic [31:0] ea);
    return (ea % m_size(op)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] ea);
    int sz = m_size(op);
    if (sz == 1) return 4'(1 << (ea % 4));
    if (sz == 2) return 4'(3 << (ea % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] sd);
    int sz = m_size(op);
    if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] ea,
                                         input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (ea % 4));
    case (op)
      LB:      return (v[7]  ? 32'hFFFF_FF00 : 32'h0) | (v & 32'hFF);
      LBU:     return v & 32'hFF;
      LH:      return (v[15] ? 32'hFFFF_0000 : 32'h0) | (v & 32'hFFFF);
      LHU:     return v & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete op: accept, optional wait states, ack, writeback.
  task automatic do_op(input logic [5:0] op, input logic [31:0] base, input logic [31:0] imm,
                       input logic [4:0] rt, input logic [31:0] sd, input int waits,
                       input logic [31:0] rdata);
    logic [31:0] ea;
    logic [68:0] got_req, exp_req;
    ea = base + imm;
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_accept: got %b want 1", ready_o);
    end
    valid_i      = 1'b1;
    opcode_i     = op;
    base_i       = base;
    imm_ext_i    = imm;
    rt_i         = rt;
    store_data_i = sd;
    tick();
    valid_i      = 1'b0;
    base_i       = $urandom;
    imm_ext_i    = $urandom;
    store_data_i = $urandom;
    rt_i         = 5'($urandom);
    if (m_misaligned(op, ea)) begin
      exp_badaddr = ea;
      n_checks++;
      if ({exc_misalign_o, mem_req_o, ready_o, exc_badaddr_o} !== {3'b100, ea}) begin
        n_fail++;
        $display("FAIL misalign_pulse: got exc/req/rdy=%b%b%b bad=%h want 100 bad=%h",
                 exc_misalign_o, mem_req_o, ready_o, exc_badaddr_o, ea);
      end
      tick();
      n_checks++;
      if ({exc_misalign_o, mem_req_o, ready_o} !== 3'b001) begin
        n_fail++;
        $display("FAIL misalign_end: got exc/req/rdy=%b%b%b want 001",
                 exc_misalign_o, mem_req_o, ready_o);
      end
    end else begin
      for (int i = 0; i <= waits; i++) begin
        got_req = {mem_req_o, mem_we_o, mem_addr_o, mem_be_o,
                   m_store(op) ? mem_wdata_o : 32'h0};
        exp_req = {1'b1, m_store(op), ea & 32'hFFFF_FFFC, m_be(op, ea),
                   m_store(op) ? m_wdata(op, sd) : 32'h0};
        n_checks++;
        if (got_req !== exp_req) begin
          n_fail++;
          $display("FAIL access_cycle%0d: got req/we/addr/be/wdata=%h want %h", i, got_req,
                   exp_req);
        end
        mem_ack_i   = (i == waits);
        mem_rdata_i = (i == waits) ? rdata : $urandom;
        tick();
      end
      mem_ack_i = 1'b0;
      if (m_store(op)) begin
        n_checks++;
        if ({wb_valid_o, mem_req_o, ready_o} !== 3'b001) begin
          n_fail++;
          $display("FAIL store_done: got wb/req/rdy=%b%b%b want 001",
                   wb_valid_o, mem_req_o, ready_o);
        end
      end else begin
        n_checks++;
        if ({wb_valid_o, mem_req_o, ready_o, wb_rd_o, wb_data_o} !==
            {3'b100, rt, m_load(op, ea, rdata)}) begin
          n_fail++;
          $display("FAIL load_wb: got wb/req/rdy=%b%b%b rd=%0d data=%h want 100 rd=%0d data=%h",
                   wb_valid_o, mem_req_o, ready_o, wb_rd_o, wb_data_o, rt,
                   m_load(op, ea, rdata));
        end
        tick();
        n_checks++;
        if ({wb_valid_o, ready_o} !== 2'b01) begin
          n_fail++;
          $display("FAIL load_wb_end: got wb/rdy=%b%b want 01", wb_valid_o, ready_o);
        end
      end
    end
    n_checks++;
    if ({exc_badaddr_o, exc_timeout_o} !== {exp_badaddr, 1'b0}) begin
      n_fail++;
      $display("FAIL badaddr_hold: got %h tmo=%b want %h tmo=0", exc_badaddr_o, exc_timeout_o,
               exp_badaddr);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset     = 1'b1;
    valid_i   = 1'b1;
    opcode_i  = LW;
    base_i    = 32'h100;
    imm_ext_i = 32'h0;
    rt_i      = 5'd3;
    mem_ack_i = 1'b1;
    #2;
    n_checks++;
    if ({ready_o, mem_req_o, mem_we_o, wb_valid_o, exc_misalign_o, exc_timeout_o,
         mem_addr_o, mem_be_o, mem_wdata_o, wb_rd_o, wb_data_o, exc_badaddr_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b req=%b addr=%h be=%h wb=%b bad=%h want all 0",
               ready_o, mem_req_o, mem_addr_o, mem_be_o, wb_valid_o, exc_badaddr_o);
    end
    tick();
    tick();
    @(negedge clk);
    reset     = 1'b0;
    valid_i   = 1'b0;
    mem_ack_i = 1'b0;
    exp_badaddr = '0;
    #1;
    n_checks++;
    if ({ready_o, mem_req_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL ready_after_reset: got rdy/req=%b%b want 10", ready_o, mem_req_o);
    end
    tick();
  endtask

  task automatic test_directed();
    do_op(LB,  32'h0000_1000, 32'hFFFF_FFFF, 5'd7,  32'h0,         0, 32'h8000_0000);
    do_op(LHU, 32'h0000_2002, 32'h0,         5'd9,  32'h0,         0, 32'hBEEF_1234);
    do_op(SB,  32'h0000_3000, 32'h1,         5'd0,  32'h0000_00A5, 0, 32'h0);
    do_op(LW,  32'h0000_4000, 32'h2,         5'd4,  32'h0,         0, 32'h0);
    do_op(LW,  32'h0000_5000, 32'h4,         5'd0,  32'h0,         2, 32'hCAFE_F00D);
    do_op(SH,  32'h0000_6001, 32'h1,         5'd1,  32'h1234_5678, 1, 32'h0);
    do_op(LH,  32'h0000_7000, 32'h2,         5'd31, 32'h0,         0, 32'h8001_7FFF);
  endtask

  task automatic test_ignored();
    logic [5:0] bad_op;
    for (int i = 0; i < 6; i++) begin
      do bad_op = 6'($urandom); while (m_legal(bad_op));
      valid_i   = 1'b1;
      opcode_i  = bad_op;
      base_i    = $urandom;
      imm_ext_i = $urandom;
      mem_ack_i = 1'b1;
      tick();
      n_checks++;
      if ({ready_o, mem_req_o, wb_valid_o, exc_misalign_o, exc_badaddr_o} !==
          {4'b1000, exp_badaddr}) begin
        n_fail++;
        $display("FAIL ignored_op %b: got rdy/req/wb/exc=%b%b%b%b bad=%h want 1000 bad=%h",
                 bad_op, ready_o, mem_req_o, wb_valid_o, exc_misalign_o, exc_badaddr_o,
                 exp_badaddr);
      end
    end
    valid_i   = 1'b0;
    mem_ack_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    time t0;
    t0 = $time;
    do_op(LW,  32'h100, 32'h0, 5'd1, 32'h0, 0, 32'h1111_1111);
    do_op(LBU, 32'h103, 32'h0, 5'd2, 32'h0, 0, 32'h9922_3344);
    do_op(LH,  32'h106, 32'h0, 5'd3, 32'h0, 0, 32'hF00D_0000);
    n_checks++;
    if (($time - t0) != 90) begin
      n_fail++;
      $display("FAIL back_to_back_time: got %0t want 90", $time - t0);
    end
  endtask

  task automatic test_reset_mid_access();
    valid_i   = 1'b1;
    opcode_i  = SW;
    base_i    = 32'h0000_0100;
    imm_ext_i = 32'h0;
    store_data_i = 32'hDEAD_BEEF;
    tick();
    valid_i = 1'b0;
    tick();
    n_checks++;
    if (mem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_access_req: got %b want 1", mem_req_o);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({ready_o, mem_req_o, mem_we_o, wb_valid_o, exc_misalign_o, exc_timeout_o,
         mem_addr_o, mem_be_o, mem_wdata_o, wb_rd_o, wb_data_o, exc_badaddr_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_abort: got rdy=%b req=%b addr=%h be=%h wdata=%h want all 0",
               ready_o, mem_req_o, mem_addr_o, mem_be_o, mem_wdata_o);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_badaddr = '0;
    #1;
    n_checks++;
    if ({ready_o, mem_req_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL ready_after_abort: got rdy/req=%b%b want 10", ready_o, mem_req_o);
    end
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    valid_i   = 1'b1;
    opcode_i  = SW;
    base_i    = 32'h0000_0020;
    imm_ext_i = 32'h0;
    tick();
    valid_i = 1'b0;
    ok = 1'b1;
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < int'(Tmo); i++) begin
      if ({mem_req_o, exc_timeout_o} !== 2'b10) ok = 1'b0;
      tick();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout_wait: got req/tmo not 10 during %0d ACCESS cycles want 10", Tmo);
    end
    exp_badaddr = 32'h0000_0020;
    n_checks++;
    if ({mem_req_o, exc_timeout_o, ready_o, wb_valid_o, exc_badaddr_o} !==
        {4'b0110, exp_badaddr}) begin
      n_fail++;
      $display("FAIL timeout_pulse: got req/tmo/rdy/wb=%b%b%b%b bad=%h want 0110 bad=%h",
               mem_req_o, exc_timeout_o, ready_o, wb_valid_o, exc_badaddr_o, exp_badaddr);
    end
    tick();
    n_checks++;
    if ({exc_timeout_o, ready_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_end: got tmo/rdy=%b%b want 01", exc_timeout_o, ready_o);
    end
`else
    for (int i = 0; i < 20; i++) begin
      if ({mem_req_o, exc_timeout_o} !== 2'b10) ok = 1'b0;
      tick();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL no_timeout_wait: got req/tmo not 10 during 20 cycles want 10");
    end
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    n_checks++;
    if ({mem_req_o, ready_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL late_ack: got req/rdy=%b%b want 01", mem_req_o, ready_o);
    end
`endif
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    logic [5:0] op;
    logic [31:0] imm;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    for (int n = 0; n < 80; n++) begin
      op  = ops[$urandom_range(7)];
      imm = ($urandom_range(1) == 1) ? 32'($signed(16'($urandom))) : $urandom;
      do_op(op, $urandom, imm, 5'($urandom), $urandom, $urandom_range(2), $urandom);
      if ($urandom_range(1) == 1) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = $urandom;
        tick();
        mem_ack_i = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    exp_badaddr  = '0;
    valid_i      = 1'b0;
    opcode_i     = '0;
    base_i       = '0;
    imm_ext_i    = '0;
    store_data_i = '0;
    rt_i         = '0;
    mem_rdata_i  = '0;
    mem_ack_i    = 1'b0;
    test_reset();
    test_directed();
    test_ignored();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, ACCESS-state cycles without mem_ack_i before abort; used only under LSU_TIMEOUT_EN.
REQ-002 SHALL have ports (name direction width meaning), clock and reset first; single clock, reset asynchronous active-high:
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high
  valid_i  in  1  decode presents a memory op
  ready_o  out  1  unit can accept an op
  opcode_i  in  6  MIPS opcode
  base_i  in  32  rs value
  imm_ext_i  in  32  extended 16-bit offset from decode
  store_data_i  in  32  rt value for stores
  rt_i  in  5  load destination register
  mem_req_o  out  1  memory request
  mem_we_o  out  1  1 = write
  mem_addr_o  out  32  word-aligned address
  mem_be_o  out  4  byte enables, bit n = bits 8n+7:8n
  mem_wdata_o  out  32  write data
  mem_rdata_i  in  32  read data, valid with mem_ack_i
  mem_ack_i  in  1  memory completion
  wb_valid_o  out  1  load result valid
  wb_rd_o  out  5  writeback register
  wb_data_o  out  32  extended load data
  exc_misalign_o  out  1  misaligned-access pulse
  exc_timeout_o  out  1  memory-timeout pulse
  exc_badaddr_o  out  32  faulting effective address

Function
REQ-003 SHALL accept an op on a rising edge with valid_i && ready_o && opcode_i in {lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011}; other opcodes SHALL be ignored with no state or output change.
REQ-004 SHALL compute EA = base_i + imm_ext_i modulo 2^32, registered at acceptance.
REQ-005 SHALL use FSM IDLE, ACCESS, DONE, ERR; ready_o = 1 only in IDLE.
REQ-006 On acceptance: misaligned (lh/lhu/sh with EA[0]=1, lw/sw with EA[1:0]!=0) -> ERR, else ACCESS.
REQ-007 ERR SHALL last one cycle with exc_misalign_o=1 and issue no memory request, then go to IDLE.
REQ-008 In ACCESS, mem_req_o=1 and mem_addr_o={EA[31:2],2'b00}, mem_we_o, mem_be_o, mem_wdata_o SHALL be stable until mem_ack_i is sampled high; ack in the first ACCESS cycle SHALL be honoured.
REQ-009 Little-endian lanes: byte at EA[1:0]=k -> be bit k; half at EA[1]=h -> be 4'b0011<<2h; word -> 4'b1111.
REQ-010 Store data SHALL be replicated: sb {4{rt[7:0]}}, sh {2{rt[15:0]}}, sw rt.
REQ-011 Store ack: ACCESS -> IDLE, no wb_valid_o.
REQ-012 Load ack: capture lane, sign-extend (lb, lh) or zero-extend (lbu, lhu), -> DONE.
REQ-013 DONE SHALL last one cycle with wb_valid_o=1, wb_rd_o=rt_i captured at acceptance (0 included), wb_data_o=result; then IDLE.
REQ-014 mem_ack_i outside ACCESS SHALL be ignored.
REQ-015 exc_badaddr_o SHALL load EA on each exception pulse and hold until the next.
REQ-016 Max throughput: one op per 3 cycles (accept, ACCESS with zero-wait ack, DONE/IDLE).

Reset
REQ-017 Reset SHALL force IDLE immediately, mid-operation included, aborting any request combinationally.
REQ-018 While reset is high: ready_o, mem_req_o, mem_we_o, wb_valid_o, exc_misalign_o, exc_timeout_o = 0; mem_addr_o, mem_be_o, mem_wdata_o, wb_rd_o, wb_data_o, exc_badaddr_o = 0.
REQ-019 ready_o SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-020 Macro LSU_TIMEOUT_EN defined: counter clears on ACCESS entry; after TIMEOUT_CYCLES ACCESS cycles without ack -> IDLE, mem_req_o drops, exc_timeout_o pulses one cycle, EA to exc_badaddr_o, no writeback.
REQ-021 Macro undefined: ACCESS waits indefinitely; exc_timeout_o tied 0; port list unchanged.

Verification
REQ-022 lb base=0x1000, imm=0xFFFFFFFF, rdata=0x80000000, zero-wait ack -> mem_addr_o=0x00000FFC, be=4'b1000, wb_data_o=0xFFFFFF80.
REQ-023 lhu base=0x2002, imm=0, rdata=0xBEEF1234 -> be=4'b1100, wb_data_o=0x0000BEEF.
REQ-024 sb EA=0x3001, rt=0x000000A5 -> mem_we_o=1, be=4'b0010, wdata=0xA5A5A5A5, no wb_valid_o.
REQ-025 lw EA=0x4002 -> exc_misalign_o one cycle, exc_badaddr_o=0x00004002, mem_req_o never 1.
REQ-026 reset pulsed during ACCESS with ack withheld -> mem_req_o=0 immediately, ready_o=1 after release; with LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> exc_timeout_o after 4 ACCESS cycles.
